// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding and
// a one-hot helper used to build grant/ack vectors from an index.
package fifo_arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } arb_state_e;

    localparam int ONEHOT_W = 32;

    // Bit idx set when idx is a legal index below n; all zeros otherwise.
    function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int n);
        logic [ONEHOT_W-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < ONEHOT_W) begin
            v = ONEHOT_W'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: finds the first requester after last_i,
// wrapping from N-1 back to 0, so non-power-of-2 N works.
module fifo_rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] pick_o
);

    int idx;

    // Walk the candidates from farthest to nearest so the nearest match wins.
    always_comb begin
        valid_o = 1'b0;
        pick_o  = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                valid_o = 1'b1;
                pick_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between N producers; grants
// bounded bursts, muxes the owner's word onto the write bus and stalls on full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] data_in_i,
    input  logic           full_i,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   ack_o,
    output logic [W-1:0]   wrt_o,
    output logic           wrt_en_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

    arb_state_e    state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] last_q;
    logic [BW-1:0] burst_q;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          in_grant;
    logic          owner_req;
    logic          push;
    logic          last_beat;
    logic [N-1:0]  owner_oh;

    fifo_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .pick_o  (pick_idx)
    );

    assign in_grant  = (state_q == S_GRANT);
    assign owner_req = req_i[owner_q];
    assign push      = in_grant & owner_req & ~full_i;
    assign last_beat = (burst_q == BW'(MAX_BURST - 1));
    assign owner_oh  = N'(onehot(int'(owner_q), N));

    // Outputs decode straight from state so an async reset clears them at once.
    assign gnt_o    = in_grant ? owner_oh : '0;
    assign ack_o    = push ? owner_oh : '0;
    assign wrt_en_o = push;
    assign wrt_o    = in_grant ? data_in_i[int'(owner_q)*W +: W] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            burst_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        burst_q <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A dropped request releases even while the FIFO is full.
                    if (!owner_req || (push && last_beat)) begin
                        last_q  <= owner_q;
                        state_q <= S_IDLE;
                    end else if (push) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations plus a per-cycle behavioural model and a random scoreboard run.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           full;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   ack_o;
    logic [W-1:0]   wrt_o;
    logic           wrt_en_o;

    logic [W-1:0]   pdata [N];
    int             n_cmp = 0;
    int             n_bad = 0;

    // Behavioural model: owner is -1 when nobody holds the port.
    int  m_owner = -1;
    int  m_last  = N - 1;
    int  m_beats = 0;

    bit  rand_phase = 1'b0;
    bit  adv [N];
    int  seq [N];
    int  wr_cnt [N];
    int  ack_cnt [N];
    int  wait_cnt [N];
    int  max_wait = 0;

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (req),
        .data_in_i (data_in),
        .full_i    (full),
        .gnt_o     (gnt_o),
        .ack_o     (ack_o),
        .wrt_o     (wrt_o),
        .wrt_en_o  (wrt_en_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < N; i++) begin
            data_in[i*W +: W] = pdata[i];
        end
    end

    function automatic logic [W-1:0] word_of(input int p, input int k);
        return W'(p * 7 + k * 3 + 5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model one edge.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic         ewe;
        logic [W-1:0] ew;
        bit           mpush;
        bit           found;
        int           c;
        int           o;
        eg = '0; ea = '0; ewe = 1'b0; ew = '0; mpush = 1'b0; found = 1'b0; c = 0; o = 0;
        if (reset) begin
            m_owner = -1;
            m_last  = N - 1;
            m_beats = 0;
        end else if (m_owner >= 0) begin
            eg    = N'(1 << m_owner);
            mpush = req[m_owner] && !full;
            ea    = mpush ? eg : '0;
            ewe   = mpush;
            ew    = pdata[m_owner];
        end
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("ack", 32'(ack_o), 32'(ea));
        chk("wrt_en", 32'(wrt_en_o), 32'(ewe));
        chk("wrt", 32'(wrt_o), 32'(ew));

        if (!reset) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (mpush) begin
                m_beats++;
                if (m_beats == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end

        if (rand_phase) begin
            chk("no_wr_on_full", 32'(wrt_en_o & full), 32'd0);
            chk("one_ack", 32'($countones(ack_o) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                adv[i] = ack_o[i];
                if (ack_o[i]) ack_cnt[i]++;
                if (gnt_o[i]) o = i;
            end
            if (wrt_en_o) begin
                chk("sb_word", 32'(wrt_o), 32'(word_of(o, wr_cnt[o])));
                wr_cnt[o]++;
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] || gnt_o[i]) begin
                    wait_cnt[i] = 0;
                end else if (gnt_o != '0 && !(full && ((gnt_o & req) != '0))) begin
                    wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic f);
        @(posedge clk);
        #1;
        req  = r;
        full = f;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = '0;
        full  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [11:0]  pat2;
    logic [N-1:0] exp_g;

    initial begin
        logic [N-1:0] g4  [9];
        logic         we4 [9];
        logic [N-1:0] r5  [10];
        logic [N-1:0] g5  [10];
        logic [N-1:0] a5  [10];
        reset = 1'b1;
        req   = '0;
        full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            pdata[i] = W'(i + 1);
            seq[i] = 0; wr_cnt[i] = 0; ack_cnt[i] = 0; wait_cnt[i] = 0; adv[i] = 1'b0;
        end

        // 1. Reset mid-burst while producer 2 owns the port.
        do_reset();
        step(4'b0100, 1'b0);
        chk("t1_idle_gnt", 32'(gnt_o), 32'h0);
        step(4'b0100, 1'b0);
        chk("t1_gnt", 32'(gnt_o), 32'h4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t1_rst_gnt", 32'(gnt_o), 32'h0);
        chk("t1_rst_ack", 32'(ack_o), 32'h0);
        chk("t1_rst_wen", 32'(wrt_en_o), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t1_post_idle", 32'(gnt_o), 32'h0);
        step(4'b0100, 1'b0);
        chk("t1_regrant", 32'(gnt_o), 32'h4);

        // 2. Single producer 1 with a constant word.
        do_reset();
        pdata[1] = 4'hA;
        pat2 = 12'b0111_1011_1101;
        for (int c = 0; c < 12; c++) begin
            step(4'b0010, 1'b0);
            chk($sformatf("t2_ack1_c%0d", c), 32'(ack_o[1]), 32'(pat2[11-c]));
            if (wrt_en_o) chk("t2_wrt", 32'(wrt_o), 32'hA);
        end

        // 3. All producers: order 0,1,2,3,0 with one bubble between bursts.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            step(4'b1111, 1'b0);
            exp_g = (c % 5 == 0) ? '0 : N'(1 << ((c / 5) % N));
            chk($sformatf("t3_gnt_c%0d", c), 32'(gnt_o), 32'(exp_g));
        end

        // 4. Full stall for three cycles after beat 2 of producer 0.
        do_reset();
        g4  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        we4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 9; c++) begin
            step(4'b0001, (c >= 3 && c <= 5));
            chk($sformatf("t4_gnt_c%0d", c), 32'(gnt_o), 32'(g4[c]));
            chk($sformatf("t4_wen_c%0d", c), 32'(wrt_en_o), 32'(we4[c]));
        end

        // 5. Producer 3 drops after two beats while producer 0 waits.
        do_reset();
        r5 = '{4'h8, 4'h9, 4'h9, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
        g5 = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        a5 = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        for (int c = 0; c < 10; c++) begin
            step(r5[c], 1'b0);
            chk($sformatf("t5_gnt_c%0d", c), 32'(gnt_o), 32'(g5[c]));
            chk($sformatf("t5_ack_c%0d", c), 32'(ack_o), 32'(a5[c]));
        end

        // 6. Random requests and full with a per-producer scoreboard.
        do_reset();
        for (int i = 0; i < N; i++) pdata[i] = word_of(i, 0);
        rand_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (adv[i]) begin
                    seq[i]++;
                    pdata[i] = word_of(i, seq[i]);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end
                adv[i] = 1'b0;
                if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
            end
            full = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rand_phase = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t6_writes_vs_acks_p%0d", i), 32'(wr_cnt[i]), 32'(ack_cnt[i]));
        end
        chk("t6_max_wait_le_15", 32'(max_wait <= (N - 1) * (MB + 1)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
